// File: rtl/bnn_layer_sequencer.sv
// Multi-layer binary-NN inference sequencer: walks each layer's output groups over a
// ping-pong activation buffer, issuing weight/activation/alpha reads and datapath strobes.
module bnn_layer_sequencer #(
    parameter int LANES     = 16,
    parameter int WEIGHT_AW = 9,
    parameter int ACT_AW    = 7,
    parameter int ALPHA_AW  = 8,
    parameter int RD_LAT    = 1,
    parameter int LAYER_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LAYER_W-1:0]       cfg_layers,
    input  logic                     stall,
    output logic [LAYER_W-1:0]       layer_idx,
    input  logic [ACT_AW-1:0]        cfg_in_words,
    input  logic [ACT_AW-1:0]        cfg_out_groups,
    output logic                     idle,
    output logic                     done,
    output logic                     cfg_err,
    output logic [LANES-1:0]         load,
    output logic [$clog2(LANES)-1:0] sum_shift,
    output logic                     sum_enb,
    output logic                     sum_clr,
    output logic                     beta_enb,
    output logic [WEIGHT_AW-1:0]     weight_addr_rd,
    output logic [ACT_AW-1:0]        activation_addr_rd,
    output logic [ACT_AW-1:0]        activation_addr_wr,
    output logic [LANES-1:0]         activation_enb_wr,
    output logic [ALPHA_AW-1:0]      alpha_addr_rd
);

    localparam int SW = $clog2(LANES);
    localparam int KW = SW + 1;
    localparam int DW = $clog2(RD_LAT + 1);
    localparam logic [ACT_AW-1:0] HALF_A = {1'b1, {(ACT_AW-1){1'b0}}};
    localparam logic [LANES-1:0]  ONE_L  = {{(LANES-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_ACCUM, S_DRAIN_A, S_NORM, S_DRAIN_N, S_WRITE, S_DONE
    } state_t;

    state_t               state_q;
    logic [LAYER_W-1:0]   layers_q, layer_idx_q;
    logic [ACT_AW-1:0]    in_words_q, groups_q, i_q, g_q;
    logic [KW-1:0]        k_q;
    logic [DW-1:0]        dly_q;
    logic                 bank_q;
    logic [WEIGHT_AW-1:0] wcnt_q, weight_addr_q;
    logic [ALPHA_AW-1:0]  acnt_q, alpha_addr_q;
    logic [ACT_AW-1:0]    act_rd_q, act_wr_q;
    logic [LANES-1:0]     enb_wr_q, load_q;
    logic [SW-1:0]        sum_shift_q;
    logic                 idle_q, done_q, err_q, sum_enb_q, sum_clr_q, beta_enb_q;

    // Read-latency delay lines: a token enters at the address edge and leaves RD_LAT edges later.
    logic [RD_LAT-1:0]         acc_vld_p, acc_clr_p, nrm_vld_p;
    logic [RD_LAT-1:0][SW-1:0] nrm_k_p;

    logic [ACT_AW-1:0] rd_base, wr_base;
    logic              dims_ok, last_layer;

    assign rd_base    = bank_q ? HALF_A : '0;
    assign wr_base    = bank_q ? '0 : HALF_A;
    assign dims_ok    = (cfg_in_words != '0) && (cfg_in_words <= HALF_A) &&
                        (cfg_out_groups != '0) && (cfg_out_groups <= HALF_A);
    assign last_layer = (layer_idx_q + 1'b1) == layers_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            layers_q      <= '0;
            layer_idx_q   <= '0;
            in_words_q    <= '0;
            groups_q      <= '0;
            i_q           <= '0;
            g_q           <= '0;
            k_q           <= '0;
            dly_q         <= '0;
            bank_q        <= 1'b0;
            wcnt_q        <= '0;
            acnt_q        <= '0;
            weight_addr_q <= '0;
            alpha_addr_q  <= '0;
            act_rd_q      <= '0;
            act_wr_q      <= '0;
            enb_wr_q      <= '0;
            load_q        <= '0;
            sum_shift_q   <= '0;
            idle_q        <= 1'b1;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            sum_enb_q     <= 1'b0;
            sum_clr_q     <= 1'b0;
            beta_enb_q    <= 1'b0;
            acc_vld_p     <= '0;
            acc_clr_p     <= '0;
            nrm_vld_p     <= '0;
            nrm_k_p       <= '0;
        end else if (stall) begin
            // Pending tokens stay in the delay lines and are released once stall drops.
            sum_enb_q  <= 1'b0;
            sum_clr_q  <= 1'b0;
            beta_enb_q <= 1'b0;
            load_q     <= '0;
            enb_wr_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            acc_vld_p[0] <= 1'b0;
            acc_clr_p[0] <= 1'b0;
            nrm_vld_p[0] <= 1'b0;
            nrm_k_p[0]   <= '0;
            for (int j = 1; j < RD_LAT; j++) begin
                acc_vld_p[j] <= acc_vld_p[j-1];
                acc_clr_p[j] <= acc_clr_p[j-1];
                nrm_vld_p[j] <= nrm_vld_p[j-1];
                nrm_k_p[j]   <= nrm_k_p[j-1];
            end
            sum_enb_q  <= acc_vld_p[RD_LAT-1];
            sum_clr_q  <= acc_clr_p[RD_LAT-1];
            beta_enb_q <= nrm_vld_p[RD_LAT-1];
            load_q     <= nrm_vld_p[RD_LAT-1] ? (ONE_L << nrm_k_p[RD_LAT-1]) : '0;
            if (nrm_vld_p[RD_LAT-1])
                sum_shift_q <= nrm_k_p[RD_LAT-1];
            enb_wr_q <= '0;
            done_q   <= 1'b0;
            idle_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    idle_q <= 1'b1;
                    if (start) begin
                        layers_q    <= cfg_layers;
                        err_q       <= 1'b0;
                        wcnt_q      <= '0;
                        acnt_q      <= '0;
                        layer_idx_q <= '0;
                        bank_q      <= 1'b0;
                        idle_q      <= 1'b0;
                        state_q     <= S_CFG;
                    end
                end
                S_CFG: begin
                    if (layers_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (!dims_ok) begin
                        err_q <= 1'b1;
                        if (last_layer) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            layer_idx_q <= layer_idx_q + 1'b1;
                        end
                    end else begin
                        in_words_q    <= cfg_in_words;
                        groups_q      <= cfg_out_groups;
                        g_q           <= '0;
                        act_rd_q      <= rd_base;
                        weight_addr_q <= wcnt_q;
                        wcnt_q        <= wcnt_q + 1'b1;
                        acc_vld_p[0]  <= 1'b1;
                        acc_clr_p[0]  <= 1'b1;
                        i_q           <= {{(ACT_AW-1){1'b0}}, 1'b1};
                        state_q       <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (i_q == in_words_q) begin
                        dly_q   <= DW'(RD_LAT - 1);
                        state_q <= S_DRAIN_A;
                    end else begin
                        act_rd_q      <= rd_base + i_q;
                        weight_addr_q <= wcnt_q;
                        wcnt_q        <= wcnt_q + 1'b1;
                        acc_vld_p[0]  <= 1'b1;
                        i_q           <= i_q + 1'b1;
                    end
                end
                S_DRAIN_A: begin
                    if (dly_q == '0) begin
                        alpha_addr_q <= acnt_q;
                        acnt_q       <= acnt_q + 1'b1;
                        nrm_vld_p[0] <= 1'b1;
                        k_q          <= {{(KW-1){1'b0}}, 1'b1};
                        state_q      <= S_NORM;
                    end else begin
                        dly_q <= dly_q - 1'b1;
                    end
                end
                S_NORM: begin
                    if (k_q == KW'(LANES)) begin
                        dly_q   <= DW'(RD_LAT - 1);
                        state_q <= S_DRAIN_N;
                    end else begin
                        alpha_addr_q <= acnt_q;
                        acnt_q       <= acnt_q + 1'b1;
                        nrm_vld_p[0] <= 1'b1;
                        nrm_k_p[0]   <= k_q[SW-1:0];
                        k_q          <= k_q + 1'b1;
                    end
                end
                S_DRAIN_N: begin
                    if (dly_q == '0) begin
                        act_wr_q <= wr_base + g_q;
                        enb_wr_q <= '1;
                        state_q  <= S_WRITE;
                    end else begin
                        dly_q <= dly_q - 1'b1;
                    end
                end
                S_WRITE: begin
                    if ((g_q + 1'b1) != groups_q) begin
                        g_q           <= g_q + 1'b1;
                        act_rd_q      <= rd_base;
                        weight_addr_q <= wcnt_q;
                        wcnt_q        <= wcnt_q + 1'b1;
                        acc_vld_p[0]  <= 1'b1;
                        acc_clr_p[0]  <= 1'b1;
                        i_q           <= {{(ACT_AW-1){1'b0}}, 1'b1};
                        state_q       <= S_ACCUM;
                    end else begin
                        bank_q <= ~bank_q;
                        if (last_layer) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            layer_idx_q <= layer_idx_q + 1'b1;
                            state_q     <= S_CFG;
                        end
                    end
                end
                S_DONE: begin
                    idle_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign layer_idx          = layer_idx_q;
    assign idle               = idle_q;
    assign done               = done_q;
    assign cfg_err            = err_q;
    assign load               = load_q;
    assign sum_shift          = sum_shift_q;
    assign sum_enb            = sum_enb_q;
    assign sum_clr            = sum_clr_q;
    assign beta_enb           = beta_enb_q;
    assign weight_addr_rd     = weight_addr_q;
    assign activation_addr_rd = act_rd_q;
    assign activation_addr_wr = act_wr_q;
    assign activation_enb_wr  = enb_wr_q;
    assign alpha_addr_rd      = alpha_addr_q;

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Bench for bnn_layer_sequencer: directed and randomized runs scored against an
// event-list model built from the layer dimensions (read/normalise/write order, run length).
module tb_bnn_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  cfg_layers = '0;
    logic        stall = 1'b0;
    logic [3:0]  layer_idx;
    logic [6:0]  cfg_in_words, cfg_out_groups;
    logic        idle, done, cfg_err;
    logic [15:0] load;
    logic [3:0]  sum_shift;
    logic        sum_enb, sum_clr, beta_enb;
    logic [8:0]  weight_addr_rd;
    logic [6:0]  activation_addr_rd, activation_addr_wr;
    logic [15:0] activation_enb_wr;
    logic [7:0]  alpha_addr_rd;

    logic [6:0] lay_in [16];
    logic [6:0] lay_og [16];

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [6:0] a; logic [8:0] w; logic c; } sum_ev_t;
    typedef struct packed { logic [7:0] a; logic [3:0] k; logic [15:0] ld; } beta_ev_t;
    typedef struct packed { logic [6:0] a; logic [15:0] e; } wr_ev_t;

    always #5 clk = ~clk;

    assign cfg_in_words   = lay_in[layer_idx];
    assign cfg_out_groups = lay_og[layer_idx];

    bnn_layer_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .cfg_layers(cfg_layers), .stall(stall),
        .layer_idx(layer_idx), .cfg_in_words(cfg_in_words), .cfg_out_groups(cfg_out_groups),
        .idle(idle), .done(done), .cfg_err(cfg_err), .load(load), .sum_shift(sum_shift),
        .sum_enb(sum_enb), .sum_clr(sum_clr), .beta_enb(beta_enb),
        .weight_addr_rd(weight_addr_rd), .activation_addr_rd(activation_addr_rd),
        .activation_addr_wr(activation_addr_wr), .activation_enb_wr(activation_enb_wr),
        .alpha_addr_rd(alpha_addr_rd)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_idle"}, 64'(idle), 64'd1);
        chk({tag, "_strobes"}, 64'({done, cfg_err, load, sum_shift, sum_enb, sum_clr, beta_enb}), 64'd0);
        chk({tag, "_addrs"}, 64'({weight_addr_rd, activation_addr_rd, activation_addr_wr,
                                  activation_enb_wr, alpha_addr_rd, layer_idx}), 64'd0);
    endtask

    // One complete run over layers lay_in/lay_og[0..nl-1]; stalls come from smask
    // (by cycle index after the start edge) or randomly with probability pct.
    task automatic run_case(input string nm, input int nl, input int pct,
                            input logic [63:0] smask, input bit hold_start);
        sum_ev_t  es[$], os[$];
        beta_ev_t eb[$], ob[$];
        wr_ev_t   ew[$], ow[$];
        int mw = 0, ma = 0, bank = 0, exp_cyc, nstall = 0, dcyc = -1, extra = 0;
        int rb, wb, iw, og;
        bit exp_err = 1'b0, stl = 1'b0;
        logic [6:0] pa;
        logic [8:0] pw;
        logic [7:0] pal;

        exp_cyc = (nl == 0) ? 2 : 1;
        for (int l = 0; l < nl; l++) begin
            iw = int'(lay_in[l]);
            og = int'(lay_og[l]);
            exp_cyc++;
            if (iw < 1 || iw > 64 || og < 1 || og > 64) begin
                exp_err = 1'b1;
                continue;
            end
            rb = bank ? 64 : 0;
            wb = bank ? 0 : 64;
            for (int g = 0; g < og; g++) begin
                for (int i = 0; i < iw; i++) begin
                    es.push_back('{a: 7'(rb + i), w: 9'(mw), c: (i == 0)});
                    mw++;
                end
                for (int k = 0; k < 16; k++) begin
                    eb.push_back('{a: 8'(ma), k: 4'(k), ld: 16'(32'd1 << k)});
                    ma++;
                end
                ew.push_back('{a: 7'(wb + g), e: 16'hFFFF});
            end
            exp_cyc += og * (iw + 16 + 2 + 1);
            bank ^= 1;
        end

        @(negedge clk);
        cfg_layers = 4'(nl);
        start = 1'b1;
        stall = 1'b0;
        pa = activation_addr_rd;
        pw = weight_addr_rd;
        pal = alpha_addr_rd;
        @(posedge clk);
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            if (cyc == 1) chk({nm, "_idle_drop"}, 64'(idle), 64'd0);
            if (stl)
                chk({nm, "_stall_hold"},
                    64'({sum_enb, sum_clr, beta_enb, load, activation_enb_wr,
                         activation_addr_rd, weight_addr_rd, alpha_addr_rd}),
                    64'({3'b000, 16'h0, 16'h0, pa, pw, pal}));
            if (sum_enb) os.push_back('{a: pa, w: pw, c: sum_clr});
            else if (sum_clr) os.push_back('{a: 7'h7F, w: 9'h1FF, c: 1'b1});
            if (beta_enb) ob.push_back('{a: pal, k: sum_shift, ld: load});
            else if (load != '0) ob.push_back('{a: 8'hFF, k: 4'hF, ld: load});
            if (activation_enb_wr != '0) ow.push_back('{a: activation_addr_wr, e: activation_enb_wr});
            pa = activation_addr_rd;
            pw = weight_addr_rd;
            pal = alpha_addr_rd;
            if (done) begin
                dcyc = cyc;
                chk({nm, "_idle_at_done"}, 64'(idle), 64'd0);
                break;
            end
            stl = (cyc < 64 && smask[cyc]) || (int'($urandom_range(99)) < pct);
            stall = stl;
            if (stl) nstall++;
        end
        start = 1'b0;
        stall = 1'b0;
        chk({nm, "_done_cycle"}, 64'(dcyc), 64'(exp_cyc + nstall));
        chk({nm, "_cfg_err"}, 64'(cfg_err), 64'(exp_err));
        chk({nm, "_n_sum"}, 64'(os.size()), 64'(es.size()));
        chk({nm, "_n_beta"}, 64'(ob.size()), 64'(eb.size()));
        chk({nm, "_n_write"}, 64'(ow.size()), 64'(ew.size()));
        for (int i = 0; i < es.size() && i < os.size(); i++) chk({nm, "_sum_ev"}, 64'(os[i]), 64'(es[i]));
        for (int i = 0; i < eb.size() && i < ob.size(); i++) chk({nm, "_beta_ev"}, 64'(ob[i]), 64'(eb[i]));
        for (int i = 0; i < ew.size() && i < ow.size(); i++) chk({nm, "_wr_ev"}, 64'(ow[i]), 64'(ew[i]));
        @(negedge clk);
        chk({nm, "_idle_after"}, 64'(idle), 64'd1);
        for (int i = 0; i < 6; i++) begin
            if (done) extra++;
            @(negedge clk);
        end
        chk({nm, "_single_done"}, 64'(extra), 64'd0);
    endtask

    initial begin
        int nb;
        int nl;
        for (int i = 0; i < 16; i++) begin
            lay_in[i] = 7'd1;
            lay_og[i] = 7'd1;
        end

        // reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        rst = 1'b1;

        // single layer 4 words x 2 groups
        lay_in[0] = 7'd4; lay_og[0] = 7'd2;
        run_case("one_layer", 1, 0, 64'd0, 1'b0);

        // two layers, second reads the upper bank and writes the lower one
        lay_in[1] = 7'd2; lay_og[1] = 7'd1;
        run_case("two_layer", 2, 0, 64'd0, 1'b0);

        // 3-cycle stall in ACCUM, 2-cycle stall in NORM
        run_case("stall_dir", 1, 0, (64'd1 << 3) | (64'd1 << 4) | (64'd1 << 5) |
                                    (64'd1 << 14) | (64'd1 << 15), 1'b0);

        // invalid first layer is skipped without a bank swap
        lay_in[0] = 7'd0; lay_og[0] = 7'd2;
        lay_in[1] = 7'd4; lay_og[1] = 7'd1;
        run_case("bad_layer", 2, 0, 64'd0, 1'b0);
        chk("err_sticky", 64'(cfg_err), 64'd1);
        lay_in[0] = 7'd4; lay_og[0] = 7'd2;
        run_case("err_clear", 1, 0, 64'd0, 1'b0);

        // reset in the middle of normalisation
        @(negedge clk);
        cfg_layers = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        for (int i = 0; i < 200 && nb < 5; i++) begin
            if (beta_enb) nb++;
            if (nb < 5) @(negedge clk);
        end
        chk("reached_norm", 64'(nb), 64'd5);
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("mid_reset");
        rst = 1'b1;
        nb = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done || !idle) nb++;
        end
        chk("no_done_after_rst", 64'(nb), 64'd0);
        run_case("post_rst", 1, 0, 64'd0, 1'b0);

        // start held high for the whole run, then a zero-layer run
        run_case("hold_start", 1, 0, 64'd0, 1'b1);
        run_case("zero_layers", 0, 0, 64'd0, 1'b0);

        // size boundaries: HALF words, wrap of weight and alpha counters, invalid last layer
        lay_in[0] = 7'd64; lay_og[0] = 7'd9;
        lay_in[1] = 7'd1;  lay_og[1] = 7'd64;
        lay_in[2] = 7'd65; lay_og[2] = 7'd1;
        run_case("boundary", 3, 0, 64'd0, 1'b0);

        // randomized dims (occasionally invalid) and random stalls
        for (int r = 0; r < 5; r++) begin
            nl = int'($urandom_range(1, 3));
            for (int l = 0; l < nl; l++) begin
                lay_in[l] = ($urandom_range(9) == 0) ? 7'd65 : 7'($urandom_range(0, 9));
                lay_og[l] = 7'($urandom_range(0, 3));
            end
            run_case("random", nl, 20, 64'd0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
